ex_muldiv: RTL

Execute-stage multiply/divide unit with the architectural HI/LO register pair. It is the consumer of the `funct` code that decode generates for `OP_SPECIAL` instructions. It executes MULT/MULTU in one cycle, DIV/DIVU as a 32-iteration restoring divider that stalls the pipeline, and MFHI/MFLO/MTHI/MTLO. It sits beside the main ALU in EX; its `result` feeds the EX result mux.

---
 rtl/ex_muldiv_pkg.sv | 33 +++
 rtl/ex_muldiv_if.sv | 26 ++
 rtl/ex_muldiv_div_iter.sv | 65 ++++++
 rtl/ex_muldiv.sv | 105 ++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the EX multiply/divide unit: bus widths,
// funct codes, FSM state encoding and a magnitude helper.
package ex_muldiv_pkg;

  localparam int FUNCT_BUS = 6;
  localparam int DATA_W    = 32;
  localparam int DWORD_W   = 64;

  localparam logic [FUNCT_BUS-1:0] FUNCT_NOP   = 6'h00;
  localparam logic [FUNCT_BUS-1:0] FUNCT_MFHI  = 6'h10;
  localparam logic [FUNCT_BUS-1:0] FUNCT_MTHI  = 6'h11;
  localparam logic [FUNCT_BUS-1:0] FUNCT_MFLO  = 6'h12;
  localparam logic [FUNCT_BUS-1:0] FUNCT_MTLO  = 6'h13;
  localparam logic [FUNCT_BUS-1:0] FUNCT_MULT  = 6'h18;
  localparam logic [FUNCT_BUS-1:0] FUNCT_MULTU = 6'h19;
  localparam logic [FUNCT_BUS-1:0] FUNCT_DIV   = 6'h1A;
  localparam logic [FUNCT_BUS-1:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  // Absolute value when the operand is taken as signed.
  function automatic logic [DATA_W-1:0] mag(
    input logic [DATA_W-1:0] v,
    input logic              sgn
  );
    return (sgn && v[DATA_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-side bundle of the mul/div unit.
// master: pipeline drives en/flush/funct/operands; slave: mul/div unit.
interface ex_muldiv_if;
  import ex_muldiv_pkg::*;

  logic                 en;
  logic                 flush;
  logic [FUNCT_BUS-1:0] funct;
  logic [DATA_W-1:0]    operand_1;
  logic [DATA_W-1:0]    operand_2;
  logic                 stall_request;
  logic [DATA_W-1:0]    result;
  logic [DATA_W-1:0]    hi;
  logic [DATA_W-1:0]    lo;

  modport master (
    output en, flush, funct, operand_1, operand_2,
    input  stall_request, result, hi, lo
  );

  modport slave (
    input  en, flush, funct, operand_1, operand_2,
    output stall_request, result, hi, lo
  );

endinterface

// File: rtl/ex_muldiv_div_iter.sv
// Restoring divider datapath on magnitudes, one quotient bit per cycle.
// Ports: start_i/cancel_i/step_i control, dividend_i/divisor_i, quot_o/rem_o/done_o.
module ex_muldiv_div_iter
  import ex_muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              cancel_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] quot_o,
  output logic [DATA_W-1:0] rem_o,
  output logic              done_o
);

  logic [DATA_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [DATA_W+1:0] sh;
  logic              ge;

  // Quotient register doubles as the dividend shift source (MSB first).
  always_comb begin
    sh     = {rem_q, quot_q[DATA_W-1]};
    ge     = sh >= {2'b00, dvs_q};
    rem_d  = rem_q;
    quot_d = quot_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    if (cancel_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      rem_d  = '0;
      quot_d = dividend_i;
      dvs_d  = divisor_i;
      cnt_d  = '0;
    end else if (step_i) begin
      rem_d  = ge ? sh[DATA_W:0] - {1'b0, dvs_q} : sh[DATA_W:0];
      quot_d = {quot_q[DATA_W-2:0], ge};
      cnt_d  = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q[DATA_W-1:0];
  assign done_o = step_i && (cnt_q == 5'd31);

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit with the HI/LO register pair.
// Ports: clk, rst, bus (slave: en/flush/funct/operands in; stall/result/hi/lo out).
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave bus
);

  state_e            state_q;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic              qneg_q, rneg_q;

  logic              is_div, div_sgn, div_go, start, step, done;
  logic              is_mult, m_sgn;
  logic [DWORD_W-1:0] prod;
  logic [DATA_W-1:0] quot, rem;

  assign is_div  = bus.en &&
                   (bus.funct == FUNCT_DIV || bus.funct == FUNCT_DIVU);
  assign div_sgn = bus.funct == FUNCT_DIV;
  assign div_go  = is_div && (bus.operand_2 != '0);
  assign start   = (state_q == ST_IDLE) && div_go && !bus.flush;
  assign step    = (state_q == ST_BUSY) && !bus.flush;

  assign is_mult = bus.en &&
                   (bus.funct == FUNCT_MULT || bus.funct == FUNCT_MULTU);
  assign m_sgn   = bus.funct == FUNCT_MULT;

  // Sign-extend to 64 bits so one unsigned multiply covers both forms.
  always_comb begin
    prod = {{DATA_W{m_sgn & bus.operand_1[DATA_W-1]}}, bus.operand_1} *
           {{DATA_W{m_sgn & bus.operand_2[DATA_W-1]}}, bus.operand_2};
  end

  ex_muldiv_div_iter u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .cancel_i  (bus.flush),
    .step_i    (step),
    .dividend_i(mag(bus.operand_1, div_sgn)),
    .divisor_i (mag(bus.operand_2, div_sgn)),
    .quot_o    (quot),
    .rem_o     (rem),
    .done_o    (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else if (bus.flush) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (div_go) begin
            state_q <= ST_BUSY;
            qneg_q  <= div_sgn &&
                       (bus.operand_1[DATA_W-1] ^ bus.operand_2[DATA_W-1]);
            rneg_q  <= div_sgn && bus.operand_1[DATA_W-1];
          end else if (is_mult) begin
            hi_q <= prod[DWORD_W-1:DATA_W];
            lo_q <= prod[DATA_W-1:0];
          end else if (bus.en && bus.funct == FUNCT_MTHI) begin
            hi_q <= bus.operand_1;
          end else if (bus.en && bus.funct == FUNCT_MTLO) begin
            lo_q <= bus.operand_1;
          end
        end
        ST_BUSY: begin
          if (done) state_q <= ST_DONE;
        end
        ST_DONE: begin
          lo_q    <= qneg_q ? -quot : quot;
          hi_q    <= rneg_q ? -rem : rem;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.result = '0;
    if (bus.en) begin
      unique case (1'b1)
        bus.funct == FUNCT_MFHI: bus.result = hi_q;
        bus.funct == FUNCT_MFLO: bus.result = lo_q;
        default:                 bus.result = '0;
      endcase
    end
  end

  assign bus.stall_request = !bus.flush &&
    (((state_q == ST_IDLE) && div_go) || (state_q == ST_BUSY));
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

endmodule
